// File: rtl/phy_pkg.sv
// Shared GDDR6 PHY receive types: lane word, default geometry, input-delay FSM states.
package phy_pkg;
  localparam int PHY_NUM_DQ  = 16;
  localparam int PHY_DEL_W   = 4;
  localparam int PHY_DEL_NOM = 8;

  typedef logic [7:0] phy_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_APPLY,
    ST_FLUSH,
    ST_ACK
  } idel_state_e;
endpackage

// File: rtl/idel_block_if.sv
// Receive-side bundle between deserializer/controller and the input delay block.
// slave = delay block view, master = deserializer/controller view.
interface idel_block_if import phy_pkg::*; #(
  parameter int NUM_DQ = PHY_NUM_DQ,
  parameter int DEL_W  = PHY_DEL_W,
  parameter int CNT_W  = 8
);
  logic [NUM_DQ*DEL_W-1:0]   param_io_in_del;
  logic                      del_req;
  logic                      del_ack;
  logic                      rx_valid;
  phy_word_t [NUM_DQ-1:0]    phy_dq;
  phy_word_t [1:0]           phy_dbi_n;
  phy_word_t [1:0]           phy_edc;
  logic                      train_en;
  logic                      train_clr;
  phy_word_t                 train_pattern;
  logic                      rx_valid_d;
  phy_word_t [NUM_DQ-1:0]    phy_dq_d;
  phy_word_t [1:0]           phy_dbi_n_d;
  phy_word_t [1:0]           phy_edc_d;
  logic [NUM_DQ*CNT_W-1:0]   err_cnt;

  modport slave (
    input  param_io_in_del, del_req, rx_valid, phy_dq, phy_dbi_n, phy_edc,
           train_en, train_clr, train_pattern,
    output del_ack, rx_valid_d, phy_dq_d, phy_dbi_n_d, phy_edc_d, err_cnt
  );

  modport master (
    output param_io_in_del, del_req, rx_valid, phy_dq, phy_dbi_n, phy_edc,
           train_en, train_clr, train_pattern,
    input  del_ack, rx_valid_d, phy_dq_d, phy_dbi_n_d, phy_edc_d, err_cnt
  );
endinterface

// File: rtl/idel_lane.sv
// One DQ lane: 3-word window, 1-UI delay select, registered output, saturating mismatch count.
// Latency 1 cycle + del UI; no backpressure, the window shifts every cycle.
module idel_lane import phy_pkg::*; #(
  parameter int DEL_W = PHY_DEL_W,
  parameter int CNT_W = 8
) (
  input  logic             clk_div,
  input  logic             rst_div_n,
  input  phy_word_t        din,
  input  logic [DEL_W-1:0] del,
  input  logic             cnt_en,
  input  logic             train_clr,
  input  phy_word_t        train_pattern,
  output phy_word_t        dout,
  output logic [CNT_W-1:0] err_cnt
);
  phy_word_t   prev1, prev2;
  logic [23:0] win;
  logic [4:0]  base;

  // Bit 16+k of the window is UI k of the current word, so delay d reads from 16-d.
  assign win  = {din, prev1, prev2};
  assign base = 5'(16 - int'(del));

  always_ff @(posedge clk_div or negedge rst_div_n) begin
    if (!rst_div_n) begin
      prev1   <= '0;
      prev2   <= '0;
      dout    <= '0;
      err_cnt <= '0;
    end else begin
      prev1 <= din;
      prev2 <= prev1;
      dout  <= win[base +: 8];
      if (train_clr)
        err_cnt <= '0;
      else if (cnt_en && (dout != train_pattern) && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/idel_block.sv
// Per-lane DQ input delay with idle-gated update handshake; DBI_n/EDC/valid fixed at 2 cycles.
// Latency 1 cycle + d UI on DQ; no backpressure, updates wait for an idle bus.
module idel_block import phy_pkg::*; #(
  parameter int NUM_DQ = PHY_NUM_DQ,
  parameter int DEL_W  = PHY_DEL_W,
  parameter int CNT_W  = 8
) (
  input logic         clk_div,
  input logic         rst_div_n,
  idel_block_if.slave bus
);
  idel_state_e                  state, state_nxt;
  logic [1:0]                   flush_cnt, flush_cnt_nxt;
  logic                         apply;
  logic                         ack;
  logic                         vld_s1, vld_s2;
  phy_word_t [1:0]              dbi_s1, dbi_s2;
  phy_word_t [1:0]              edc_s1, edc_s2;
  logic [NUM_DQ-1:0][DEL_W-1:0] del_q;
  logic                         bus_idle;
  logic                         cnt_en;

  // Idle means nothing in flight anywhere in the 2-stage static pipe.
  assign bus_idle = !bus.rx_valid && !vld_s1 && !vld_s2;
  assign cnt_en   = vld_s2 && bus.train_en;

  always_ff @(posedge clk_div or negedge rst_div_n) begin
    if (!rst_div_n) begin
      vld_s1 <= 1'b0;
      vld_s2 <= 1'b0;
      dbi_s1 <= '1;
      dbi_s2 <= '1;
      edc_s1 <= '0;
      edc_s2 <= '0;
    end else begin
      vld_s1 <= bus.rx_valid;
      vld_s2 <= vld_s1;
      dbi_s1 <= bus.phy_dbi_n;
      dbi_s2 <= dbi_s1;
      edc_s1 <= bus.phy_edc;
      edc_s2 <= edc_s1;
    end
  end

  assign bus.rx_valid_d  = vld_s2;
  assign bus.phy_dbi_n_d = dbi_s2;
  assign bus.phy_edc_d   = edc_s2;
  assign bus.del_ack     = ack;

  always_ff @(posedge clk_div or negedge rst_div_n) begin
    if (!rst_div_n) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      del_q     <= {NUM_DQ{DEL_W'(PHY_DEL_NOM)}};
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (apply)
        del_q <= bus.param_io_in_del;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    apply         = 1'b0;
    ack           = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.del_req)
          state_nxt = bus_idle ? ST_APPLY : ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.del_req)
          state_nxt = ST_IDLE;
        else if (bus_idle)
          state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        apply         = 1'b1;
        flush_cnt_nxt = '0;
        state_nxt     = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_cnt_nxt = flush_cnt + 2'd1;
        if (flush_cnt == 2'd2)
          state_nxt = ST_ACK;
      end
      ST_ACK: begin
        ack       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  for (genvar l = 0; l < NUM_DQ; l++) begin : g_lane
    idel_lane #(
      .DEL_W (DEL_W),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk_div       (clk_div),
      .rst_div_n     (rst_div_n),
      .din           (bus.phy_dq[l]),
      .del           (del_q[l]),
      .cnt_en        (cnt_en),
      .train_clr     (bus.train_clr),
      .train_pattern (bus.train_pattern),
      .dout          (bus.phy_dq_d[l]),
      .err_cnt       (bus.err_cnt[l*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_idel_block.sv
// Directed bench for idel_block: delay alignment, update handshake, training counters, reset.
module tb_idel_block;
  import phy_pkg::*;

  localparam int NUM_DQ = 16;
  localparam int DEL_W  = 4;
  localparam int CNT_W  = 8;
  localparam int PULSE  = 40;

  logic clk_div   = 1'b0;
  logic rst_div_n = 1'b0;

  idel_block_if #(.NUM_DQ(NUM_DQ), .DEL_W(DEL_W), .CNT_W(CNT_W)) bus ();

  idel_block #(.NUM_DQ(NUM_DQ), .DEL_W(DEL_W), .CNT_W(CNT_W)) dut (
    .clk_div   (clk_div),
    .rst_div_n (rst_div_n),
    .bus       (bus)
  );

  always #5 clk_div = ~clk_div;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_div);
    #1;
  endtask

  // Output word n of a stream whose only set UI is 'pos', seen through delay d (d=0 gives the input word).
  function automatic phy_word_t pulse_word(input int n, input int d, input int pos);
    phy_word_t w;
    w = '0;
    for (int k = 0; k < 8; k++)
      w[k] = ((8 * n + k - d) == pos);
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] lane_cnt(input int l);
    logic [NUM_DQ*CNT_W-1:0] all;
    all = bus.err_cnt;
    return all[l*CNT_W +: CNT_W];
  endfunction

  initial begin
    logic [NUM_DQ*DEL_W-1:0] p;
    logic [NUM_DQ*CNT_W-1:0] others;
    int cyc;
    int acks;

    bus.param_io_in_del = {NUM_DQ{4'd8}};
    bus.del_req         = 1'b0;
    bus.rx_valid        = 1'b0;
    bus.phy_dq          = '0;
    bus.phy_dbi_n       = '1;
    bus.phy_edc         = '0;
    bus.train_en        = 1'b0;
    bus.train_clr       = 1'b0;
    bus.train_pattern   = 8'hA5;

    // Reset state
    #12;
    check("rst_ack",    bus.del_ack,     1'b0);
    check("rst_vld",    bus.rx_valid_d,  1'b0);
    check("rst_dq",     bus.phy_dq_d,    '0);
    check("rst_dbi",    bus.phy_dbi_n_d, 16'hFFFF);
    check("rst_edc",    bus.phy_edc_d,   16'h0000);
    check("rst_cnt",    bus.err_cnt,     '0);
    @(negedge clk_div);
    rst_div_n = 1'b1;
    tick();

    // 1: nominal d=8, pulse at UI 40 on lane 0
    for (int n = 0; n <= 8; n++) begin
      bus.phy_dq[0] = pulse_word(n, 0, PULSE);
      bus.rx_valid  = 1'b1;
      tick();
      check("t1_dq0", bus.phy_dq_d[0], pulse_word(n, 8, PULSE));
      check("t1_vld", bus.rx_valid_d, (n >= 1));
    end
    bus.phy_dq   = '0;
    bus.rx_valid = 1'b0;
    repeat (3) tick();

    // 2: lane 0 -> d=3, lane 15 -> d=15 on an idle bus
    p = {NUM_DQ{4'd8}};
    p[0*DEL_W +: DEL_W]  = 4'd3;
    p[15*DEL_W +: DEL_W] = 4'd15;
    bus.param_io_in_del = p;
    bus.del_req = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.del_ack) begin
        cyc = i;
        break;
      end
    end
    check("t2_ack_lat", cyc, 5);
    bus.del_req = 1'b0;
    tick();
    check("t2_ack_pulse", bus.del_ack, 1'b0);
    for (int n = 0; n <= 8; n++) begin
      bus.phy_dq[0]  = pulse_word(n, 0, PULSE);
      bus.phy_dq[15] = pulse_word(n, 0, PULSE);
      tick();
      check("t2_dq0",  bus.phy_dq_d[0],  pulse_word(n, 3, PULSE));
      check("t2_dq15", bus.phy_dq_d[15], pulse_word(n, 15, PULSE));
    end
    bus.phy_dq = '0;
    repeat (3) tick();

    // 6: DBI_n / EDC fixed 2-cycle delay under non-nominal DQ codes
    bus.phy_dbi_n[1] = 8'h3C;
    bus.phy_edc[0]   = 8'h5A;
    tick();
    bus.phy_dbi_n = '1;
    bus.phy_edc   = '0;
    check("t6_dbi_c1", bus.phy_dbi_n_d[1], 8'hFF);
    check("t6_edc_c1", bus.phy_edc_d[0],   8'h00);
    tick();
    check("t6_dbi_c2", bus.phy_dbi_n_d[1], 8'h3C);
    check("t6_edc_c2", bus.phy_edc_d[0],   8'h5A);
    check("t6_dbi0",   bus.phy_dbi_n_d[0], 8'hFF);
    tick();
    check("t6_dbi_c3", bus.phy_dbi_n_d[1], 8'hFF);

    // 3: request while bus busy, then released
    bus.param_io_in_del = {NUM_DQ{4'd8}};
    bus.rx_valid = 1'b1;
    bus.del_req  = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.del_ack) acks++;
    end
    check("t3_busy_acks", acks, 0);
    check("t3_wait", dut.state, ST_WAIT);
    bus.rx_valid = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.del_ack) begin
        cyc = i;
        break;
      end
    end
    // valid_s2 clears after edge 2, ack 5 cycles later
    check("t3_ack_lat", cyc, 7);
    bus.del_req = 1'b0;
    tick();

    bus.rx_valid = 1'b1;
    bus.del_req  = 1'b1;
    repeat (3) tick();
    check("t3_wait2", dut.state, ST_WAIT);
    bus.del_req = 1'b0;
    tick();
    bus.rx_valid = 1'b0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.del_ack) acks++;
    end
    check("t3_drop_acks", acks, 0);
    check("t3_idle", dut.state, ST_IDLE);

    // 4: training counters, lane 2 mismatches
    for (int l = 0; l < NUM_DQ; l++) bus.phy_dq[l] = 8'hA5;
    bus.phy_dq[2] = 8'hA4;
    bus.train_en  = 1'b1;
    bus.rx_valid  = 1'b1;
    repeat (300) tick();
    bus.rx_valid = 1'b0;
    repeat (4) tick();
    check("t4_lane2_sat", lane_cnt(2), 8'd255);
    others = bus.err_cnt;
    others[2*CNT_W +: CNT_W] = '0;
    check("t4_others", others, '0);
    bus.rx_valid = 1'b1;
    repeat (3) tick();
    bus.train_clr = 1'b1;
    tick();
    check("t4_clr", lane_cnt(2), 8'd0);
    bus.train_clr = 1'b0;
    tick();
    check("t4_resume", lane_cnt(2), 8'd1);
    bus.rx_valid = 1'b0;
    bus.train_en = 1'b0;
    bus.phy_dq   = '0;
    repeat (3) tick();

    // 5: reset during FLUSH
    p = {NUM_DQ{4'd8}};
    p[0*DEL_W +: DEL_W] = 4'd3;
    bus.param_io_in_del = p;
    bus.del_req = 1'b1;
    repeat (3) tick();
    check("t5_flush", dut.state, ST_FLUSH);
    #2;
    rst_div_n = 1'b0;
    #1;
    bus.del_req = 1'b0;
    check("t5_state", dut.state, ST_IDLE);
    check("t5_ack",   bus.del_ack, 1'b0);
    check("t5_cnt",   bus.err_cnt, '0);
    check("t5_dbi",   bus.phy_dbi_n_d, 16'hFFFF);
    check("t5_vld",   bus.rx_valid_d, 1'b0);
    @(negedge clk_div);
    rst_div_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.del_ack) acks++;
    end
    check("t5_no_ack", acks, 0);
    for (int n = 0; n <= 8; n++) begin
      bus.phy_dq[0] = pulse_word(n, 0, PULSE);
      bus.rx_valid  = 1'b1;
      tick();
      check("t5_dq0_d8", bus.phy_dq_d[0], pulse_word(n, 8, PULSE));
    end
    bus.rx_valid = 1'b0;
    bus.phy_dq   = '0;
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end
endmodule
